// File: rtl/fwb_slave.sv
// Wishbone pipelined-slave protocol checker: tracks request/ack counts and
// raises sticky fault flags for illegal master (bits 0-3) or slave (bits 4-7) behaviour.
module fwb_slave #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int F_LGDEPTH       = 4,
  parameter int F_MAX_STALL     = 0,
  parameter int F_MAX_ACK_DELAY = 0,
  parameter int F_MAX_REQUESTS  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic [DW-1:0]        i_wb_idata,
  input  logic                 i_wb_err,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic [7:0]           f_fault
);

  localparam int REQ_LIMIT = (F_MAX_REQUESTS == 0) ? (2**F_LGDEPTH - 2) : F_MAX_REQUESTS;
  localparam int SW        = $clog2(F_MAX_STALL + 2);
  localparam int DLW       = $clog2(F_MAX_ACK_DELAY + 2);

  logic            accepted, response, waiting;
  logic            past_reset, prev_cyc, prev_stb, prev_stall, prev_err;
  logic            prev_we, stb_seen, cyc_we;
  logic [AW-1:0]   prev_addr;
  logic [DW-1:0]   prev_data;
  logic [DW/8-1:0] prev_sel;
  logic [SW-1:0]   stall_cnt;
  logic [DLW-1:0]  ack_cnt;
  logic [7:0]      viol;
  logic            unused_idata;

  assign accepted      = i_wb_stb && !i_wb_stall;
  assign response      = i_wb_ack || i_wb_err;
  assign f_outstanding = i_wb_cyc ? (f_nreqs - f_nacks) : '0;
  assign waiting       = i_wb_cyc && !response && (f_outstanding != '0);
  assign unused_idata  = ^i_wb_idata;

  // Bus-cycle transaction counters; an error aborts the whole cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc || i_wb_err) begin
      f_nreqs <= '0;
      f_nacks <= '0;
    end else begin
      f_nreqs <= f_nreqs + {{(F_LGDEPTH-1){1'b0}}, accepted};
      f_nacks <= f_nacks + {{(F_LGDEPTH-1){1'b0}}, response};
    end
  end

  always_ff @(posedge i_clk) begin
    past_reset <= i_reset;
    if (i_reset) begin
      prev_cyc   <= 1'b0;
      prev_stb   <= 1'b0;
      prev_stall <= 1'b0;
      prev_err   <= 1'b0;
    end else begin
      prev_cyc   <= i_wb_cyc;
      prev_stb   <= i_wb_stb;
      prev_stall <= i_wb_stall;
      prev_err   <= i_wb_err;
    end
  end

  always_ff @(posedge i_clk) begin
    prev_we   <= i_wb_we;
    prev_addr <= i_wb_addr;
    prev_data <= i_wb_data;
    prev_sel  <= i_wb_sel;
    if (i_wb_stb)
      cyc_we <= i_wb_we;
  end

  // stb_seen marks that cyc_we holds the direction of this bus cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc)
      stb_seen <= 1'b0;
    else if (i_wb_stb)
      stb_seen <= 1'b1;
  end

  // Both timers saturate at their limit so they cannot wrap past it.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc || !i_wb_stb || !i_wb_stall)
      stall_cnt <= '0;
    else if (stall_cnt != SW'(F_MAX_STALL))
      stall_cnt <= stall_cnt + SW'(1);

    if (i_reset || !waiting)
      ack_cnt <= '0;
    else if (ack_cnt != DLW'(F_MAX_ACK_DELAY))
      ack_cnt <= ack_cnt + DLW'(1);
  end

  always_comb begin
    viol = '0;
    if (past_reset && (i_wb_cyc || i_wb_stb))
      viol[0] = 1'b1;
    if (i_wb_stb && !i_wb_cyc)
      viol[0] = 1'b1;
    if (prev_cyc && prev_stb && prev_stall && i_wb_cyc
        && (!i_wb_stb || (i_wb_we != prev_we) || (i_wb_addr != prev_addr)
            || (i_wb_data != prev_data) || (i_wb_sel != prev_sel)))
      viol[1] = 1'b1;
    if (i_wb_cyc && i_wb_stb && stb_seen && (i_wb_we != cyc_we))
      viol[2] = 1'b1;
    if (i_wb_cyc && accepted && (f_nreqs >= F_LGDEPTH'(REQ_LIMIT)))
      viol[3] = 1'b1;
    if (prev_err && prev_cyc && i_wb_cyc)
      viol[3] = 1'b1;
    if ((response && !prev_cyc) || (i_wb_ack && i_wb_err))
      viol[4] = 1'b1;
    if (response && (f_outstanding == '0))
      viol[5] = 1'b1;
    if ((F_MAX_STALL != 0) && i_wb_cyc && i_wb_stb && i_wb_stall
        && (stall_cnt == SW'(F_MAX_STALL)))
      viol[6] = 1'b1;
    if ((F_MAX_ACK_DELAY != 0) && waiting && (ack_cnt == DLW'(F_MAX_ACK_DELAY)))
      viol[7] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      f_fault <= 8'h00;
    else
      f_fault <= f_fault | viol;
  end

`ifdef FORMAL
  always_comb begin
    if (!i_reset) begin
      assume (viol[3:0] == 4'h0);
      assert (viol[7:4] == 4'h0);
      assert (f_nacks <= f_nreqs);
    end
  end
`endif

endmodule

// File: tb/tb_fwb_slave.sv
// Directed bench for fwb_slave: expectations are queued per step and
// compared against the counters and fault flags after each clock.
module tb_fwb_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, cyc, stb, we, ack, stall, err;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data, idata;
  logic [DW/8-1:0] sel;
  logic [LG-1:0]   nreqs, nacks, outst;
  logic [7:0]      fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         field;
    logic [7:0] exp;
  } chk_t;
  chk_t sb[$];

  fwb_slave #(
    .AW(AW), .DW(DW), .F_LGDEPTH(LG),
    .F_MAX_STALL(6), .F_MAX_ACK_DELAY(6), .F_MAX_REQUESTS(2)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
    .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
    .f_nreqs(nreqs), .f_nacks(nacks), .f_outstanding(outst), .f_fault(fault)
  );

  task automatic idle();
    cyc = 0; stb = 0; we = 0; ack = 0; stall = 0; err = 0;
    addr = '0; data = '0; sel = '0; idata = '0;
  endtask

  task automatic push(string tag, int field, int v);
    chk_t c;
    c.tag = tag; c.field = field; c.exp = v[7:0];
    sb.push_back(c);
  endtask

  task automatic expect_all(string tag, int r, int a, int o, int f);
    push({tag, ".nreqs"}, 0, r);
    push({tag, ".nacks"}, 1, a);
    push({tag, ".outstanding"}, 2, o);
    push({tag, ".fault"}, 3, f);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      chk_t c;
      logic [7:0] obs;
      c = sb.pop_front();
      case (c.field)
        0:       obs = {4'h0, nreqs};
        1:       obs = {4'h0, nacks};
        2:       obs = {4'h0, outst};
        default: obs = fault;
      endcase
      checks++;
      assert (obs === c.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", c.tag, obs, c.exp);
      end
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1; idle();
    expect_all(tag, 0, 0, 0, 0);
    step();
    rst = 0;
    push({tag, ".release"}, 3, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; idle();
    step();
    do_reset("reset");

    // single read, ack two clocks after the request
    cyc = 1; stb = 1; addr = 32'h100; sel = 4'hf;
    expect_all("rd_req", 1, 0, 1, 0); step();
    stb = 0;
    expect_all("rd_wait", 1, 0, 1, 0); step();
    ack = 1;
    expect_all("rd_ack", 1, 1, 0, 0); step();
    idle();
    expect_all("rd_end", 0, 0, 0, 0); step();

    // pipelined pair at the request limit, then one too many
    cyc = 1; stb = 1; addr = 32'h10;
    expect_all("p_req1", 1, 0, 1, 0); step();
    addr = 32'h14; ack = 1;
    expect_all("p_req2", 2, 1, 1, 0); step();
    stb = 0; ack = 1;
    expect_all("p_ack2", 2, 2, 0, 0); step();
    stb = 1; ack = 0; addr = 32'h18;
    expect_all("p_req3", 3, 2, 1, 8'h08); step();
    idle();
    expect_all("p_sticky", 0, 0, 0, 8'h08); step();
    do_reset("p_reset");

    // ack with cyc low, then ack with nothing outstanding
    ack = 1;
    push("ack_nocyc", 3, 8'h30); step();
    do_reset("r3");
    cyc = 1;
    push("cyc_only", 3, 0); step();
    ack = 1;
    push("ack_noreq", 3, 8'h20); step();
    do_reset("r4");

    // address changes while the request is stalled
    cyc = 1; stb = 1; stall = 1; addr = 32'h200;
    expect_all("st_hold", 0, 0, 0, 0); step();
    addr = 32'h204; stall = 0;
    push("addr_chg.nreqs", 0, 1); push("addr_chg", 3, 8'h02); step();
    do_reset("r5");

    // stall for exactly the limit, then one past it
    cyc = 1; stb = 1; stall = 1; addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      push("stall6", 3, 0); step();
    end
    stall = 0;
    expect_all("stall6_acc", 1, 0, 1, 0); step();
    stb = 0; ack = 1;
    expect_all("stall6_ack", 1, 1, 0, 0); step();
    idle();
    push("stall_idle", 3, 0); step();
    cyc = 1; stb = 1; stall = 1; addr = 32'h310;
    for (int i = 0; i < 6; i++) begin
      push("stall7_pre", 3, 0); step();
    end
    push("stall7", 3, 8'h40); step();
    do_reset("r6");

    // ack delay: six waiting cycles allowed, the seventh faults
    cyc = 1; stb = 1; addr = 32'h400;
    expect_all("dly_req", 1, 0, 1, 0); step();
    stb = 0;
    for (int i = 0; i < 6; i++) begin
      push("ackdly6", 3, 0); step();
    end
    push("ackdly7", 3, 8'h80); step();

    // reset in the middle of a transfer
    stb = 1; rst = 1;
    expect_all("mid_reset", 0, 0, 0, 0); step();
    rst = 0; idle();
    expect_all("mid_release", 0, 0, 0, 0); step();

    // error clears counters, cyc must then drop
    cyc = 1; stb = 1; addr = 32'h500;
    expect_all("err_req", 1, 0, 1, 0); step();
    stb = 0; err = 1;
    expect_all("err_clr", 0, 0, 0, 0); step();
    err = 0;
    push("cyc_after_err", 3, 8'h08); step();
    do_reset("r7");

    // direction change within one bus cycle
    cyc = 1; stb = 1; we = 0; addr = 32'h600;
    push("we_first", 3, 0); step();
    we = 1; addr = 32'h604;
    push("we_chg", 3, 8'h04); step();
    do_reset("r8");

    // stb without cyc
    stb = 1;
    push("stb_nocyc", 3, 8'h01); step();
    do_reset("r9");

    // cyc raised in the first clock after reset
    rst = 1; idle(); step();
    rst = 0; cyc = 1;
    push("cyc_post_reset", 3, 8'h01); step();
    do_reset("r10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwb_slave.md
Name: fwb_slave

Overview:
- Protocol checker for a Wishbone pipelined slave port, instantiated beside a slave under formal verification or simulation.
- Watches the bus and constrains (assumes) legal master behaviour.
- Checks (asserts) legal slave behaviour.
- Exports request, acknowledge and outstanding counters so the enclosing design can tie internal state to the bus.
- Purely observational: it never drives the bus.

Parameters:
- AW, 32: address width.
- DW, 32: data width; select width is DW/8.
- F_LGDEPTH, 4: counter width.
- F_MAX_STALL, 0: max consecutive stalled-request cycles; 0 disables the check.
- F_MAX_ACK_DELAY, 0: max consecutive cycles with outstanding>0 and no ack/err; 0 disables the check.
- F_MAX_REQUESTS, 0: max requests accepted per cycle (bus cycle, CYC high); 0 limits to 2^F_LGDEPTH-2.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  master cycle.
- i_wb_stb  in  1  master strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  AW  address.
- i_wb_data  in  DW  write data.
- i_wb_sel  in  DW/8  byte selects.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_stall  in  1  slave stall.
- i_wb_idata  in  DW  slave read data (unchecked).
- i_wb_err  in  1  slave bus error.
- f_nreqs  out  F_LGDEPTH  requests accepted in current cycle.
- f_nacks  out  F_LGDEPTH  acks+errs received in current cycle.
- f_outstanding  out  F_LGDEPTH  f_nreqs-f_nacks when i_wb_cyc, else 0.
- f_fault  out  8  sticky violation flags (simulation use); bit map below.

Behaviour:
- Request accepted when i_wb_stb && !i_wb_stall; response = i_wb_ack || i_wb_err.
- Counters: on i_reset, !i_wb_cyc, or i_wb_err, both reset to 0 next cycle.
  - Otherwise f_nreqs += accepted; f_nacks += response.
  - Both update in the same cycle when events coincide.
- f_outstanding is combinational.
- f_fault reset value 0; bits set on violation and clear only on i_reset.
- Under `FORMAL`, master rules are assume properties and slave rules are assert properties.
- Master rules (bits 0-3):
  - bit0: after reset, cyc=0 and stb=0 for the first clock after i_reset.
  - bit0: stb implies cyc.
  - bit1: while stb && stall, the next cycle holds stb, we, addr, data and sel unchanged (unless cyc drops).
  - bit2: we unchanged between consecutive stb cycles within one bus cycle.
  - bit3: no request accepted when f_nreqs already equals the request limit.
  - bit3: cyc drops the cycle after i_wb_err.
- Slave rules (bits 4-7):
  - bit4: ack or err while cyc was low in the previous cycle.
  - bit4: ack && err simultaneously.
  - bit5: a response when f_outstanding==0.
    - A response in the same cycle as the accepting request is illegal; minimum latency is one clock.
  - bit6: stall counter, reset by reset/!cyc/!stb/!stall, increments on stb&&stall; fault when it exceeds F_MAX_STALL.
  - bit7: ack-delay counter, reset by reset/!cyc/response/outstanding==0, increments otherwise; fault when it exceeds F_MAX_ACK_DELAY.
- f_nacks never exceeds f_nreqs.
- Counters never wrap; the request limit guarantees f_nreqs < 2^F_LGDEPTH-1.
- Reset mid-cycle: all counters and flags clear; checks restart.

Test Plan:
- Single read: cyc/stb, stall=0, ack 2 clocks later -> f_nreqs 1, f_outstanding 1 then 0, f_nacks 1, f_fault 0.
- Two pipelined requests (F_MAX_REQUESTS=2) with acks on consecutive clocks -> f_nreqs 2, f_nacks 2, no fault; a third request sets bit3.
- Ack with cyc low or with no outstanding request -> bit4 or bit5 set next clock.
- Address changed while stb&&stall -> bit1 set.
- F_MAX_STALL=6: stb&&stall held 7 clocks -> bit6 set; held 6 clocks -> clear.
- F_MAX_ACK_DELAY=6: request accepted, no ack for 7 clocks -> bit7 set.
- Reset asserted mid-transfer -> counters and f_fault all 0 next clock.
